// File: rtl/sc_regjug_move_ctrl_pkg.sv
// Shared definitions for the player-move controller.
// Provides the game state codes, the shift command encodings used on the
// player register's shift-select port, and a small lives helper.
package sc_regjug_move_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LIVES_W = 3;
    localparam int unsigned SHIFT_W = 2;

    // Game-level state codes; values 5..7 are illegal and recover to idle.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_PLAY  = 3'd2,
        ST_HIT   = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Shift commands to the player register; 2'b11 is never driven.
    localparam logic [SHIFT_W-1:0] SHIFT_HOLD  = 2'b00;
    localparam logic [SHIFT_W-1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [SHIFT_W-1:0] SHIFT_RIGHT = 2'b10;

    // Lose one life, never going below zero.
    function automatic logic [LIVES_W-1:0] lives_dec(input logic [LIVES_W-1:0] lives);
        return (lives == LIVES_W'(0)) ? LIVES_W'(0) : lives - LIVES_W'(1);
    endfunction

endpackage

// File: rtl/sc_btn_sync_edge.sv
// Button conditioner: 2-FF synchronizer plus falling-edge detector.
// Ports:
//   SC_REGJUG_CLOCK_50      - system clock
//   SC_REGJUG_RESET_InHigh  - asynchronous active-high reset (all stages to 1)
//   i_btn_n                 - raw active-low button, asynchronous to the clock
//   o_level                 - synchronized level (0 = pressed)
//   o_fall                  - one-cycle press event (high->low of o_level)
module sc_btn_sync_edge (
    input  logic SC_REGJUG_CLOCK_50,
    input  logic SC_REGJUG_RESET_InHigh,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Synchronizer chain plus one history stage for edge detection.
    always_ff @(posedge SC_REGJUG_CLOCK_50 or posedge SC_REGJUG_RESET_InHigh) begin
        if (SC_REGJUG_RESET_InHigh) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Event is visible in the same cycle the synchronized level drops, so the
    // consumer's output register lands on the third edge after the press.
    assign o_level = r_sync2;
    assign o_fall  = r_prev & ~r_sync2;

endmodule

// File: rtl/sc_regjug_move_ctrl.sv
// Player-move controller for the register-juggle game.
// Conditions the three buttons, generates rate-limited one-cycle shift
// commands, and runs the idle/spawn/play/hit/over game FSM with lives.
// Ports:
//   SC_REGJUG_CLOCK_50                - system clock
//   SC_REGJUG_RESET_InHigh            - asynchronous active-high reset
//   SC_REGJUGCTRL_left_InLow          - raw left button (active low)
//   SC_REGJUGCTRL_right_InLow         - raw right button (active low)
//   SC_REGJUGCTRL_start_InLow         - raw start button (active low)
//   SC_REGJUGCTRL_collision_In        - player/obstacle overlap (synchronous)
//   SC_REGJUGCTRL_shiftselection_Out  - 01 left, 10 right, 00 hold
//   SC_REGJUGCTRL_clear_OutLow        - clear player register (active low)
//   SC_REGJUGCTRL_initpos_OutLow      - load initial position (active low)
//   SC_REGJUGCTRL_lives_Out           - remaining lives
//   SC_REGJUGCTRL_state_Out           - current state code
module sc_regjug_move_ctrl
    import sc_regjug_move_ctrl_pkg::*;
#(
    parameter int unsigned MOVE_TICKS = 2500000,
    parameter int unsigned TICK_WIDTH = 22,
    parameter int unsigned HIT_TICKS  = 25000000,
    parameter int unsigned HIT_WIDTH  = 25,
    parameter int unsigned LIVES_INIT = 3
) (
    input  logic                SC_REGJUG_CLOCK_50,
    input  logic                SC_REGJUG_RESET_InHigh,
    input  logic                SC_REGJUGCTRL_left_InLow,
    input  logic                SC_REGJUGCTRL_right_InLow,
    input  logic                SC_REGJUGCTRL_start_InLow,
    input  logic                SC_REGJUGCTRL_collision_In,
    output logic [SHIFT_W-1:0]  SC_REGJUGCTRL_shiftselection_Out,
    output logic                SC_REGJUGCTRL_clear_OutLow,
    output logic                SC_REGJUGCTRL_initpos_OutLow,
    output logic [LIVES_W-1:0]  SC_REGJUGCTRL_lives_Out,
    output logic [STATE_W-1:0]  SC_REGJUGCTRL_state_Out
);

    localparam logic [TICK_WIDTH-1:0] REP_LAST   = TICK_WIDTH'(MOVE_TICKS - 1);
    localparam logic [HIT_WIDTH-1:0]  HIT_LAST   = HIT_WIDTH'(HIT_TICKS - 1);
    localparam logic [LIVES_W-1:0]    LIVES_FULL = LIVES_W'(LIVES_INIT);

    logic w_left_level;
    logic w_left_fall;
    logic w_right_level;
    logic w_right_fall;
    logic w_start_level;
    logic w_start_fall;
    logic w_start_evt;

    state_t                r_state;
    logic [LIVES_W-1:0]    r_lives;
    logic [SHIFT_W-1:0]    r_shift;
    logic                  r_clear_n;
    logic                  r_initpos_n;
    logic [TICK_WIDTH-1:0] r_rep_cnt;
    logic [HIT_WIDTH-1:0]  r_hit_cnt;

    sc_btn_sync_edge u_left (
        .SC_REGJUG_CLOCK_50     (SC_REGJUG_CLOCK_50),
        .SC_REGJUG_RESET_InHigh (SC_REGJUG_RESET_InHigh),
        .i_btn_n                (SC_REGJUGCTRL_left_InLow),
        .o_level                (w_left_level),
        .o_fall                 (w_left_fall)
    );

    sc_btn_sync_edge u_right (
        .SC_REGJUG_CLOCK_50     (SC_REGJUG_CLOCK_50),
        .SC_REGJUG_RESET_InHigh (SC_REGJUG_RESET_InHigh),
        .i_btn_n                (SC_REGJUGCTRL_right_InLow),
        .o_level                (w_right_level),
        .o_fall                 (w_right_fall)
    );

    sc_btn_sync_edge u_start (
        .SC_REGJUG_CLOCK_50     (SC_REGJUG_CLOCK_50),
        .SC_REGJUG_RESET_InHigh (SC_REGJUG_RESET_InHigh),
        .i_btn_n                (SC_REGJUGCTRL_start_InLow),
        .o_level                (w_start_level),
        .o_fall                 (w_start_fall)
    );

    // Start press: fresh falling edge with the settled level low; a button
    // held across states never produces a second event.
    assign w_start_evt = w_start_fall & ~w_start_level;

    // Game FSM with counters; every output is a register updated here.
    always_ff @(posedge SC_REGJUG_CLOCK_50 or posedge SC_REGJUG_RESET_InHigh) begin
        if (SC_REGJUG_RESET_InHigh) begin
            r_state     <= ST_IDLE;
            r_lives     <= LIVES_FULL;
            r_shift     <= SHIFT_HOLD;
            r_clear_n   <= 1'b0;
            r_initpos_n <= 1'b1;
            r_rep_cnt   <= '0;
            r_hit_cnt   <= '0;
        end else begin
            // Shift commands are single-cycle pulses unless re-issued below.
            r_shift <= SHIFT_HOLD;

            case (r_state)
                ST_IDLE: begin
                    r_clear_n   <= 1'b0;
                    r_initpos_n <= 1'b1;
                    r_rep_cnt   <= '0;
                    r_hit_cnt   <= '0;
                    if (w_start_evt) begin
                        r_state     <= ST_SPAWN;
                        r_lives     <= LIVES_FULL;
                        r_clear_n   <= 1'b1;
                        r_initpos_n <= 1'b0;
                    end
                end

                ST_SPAWN: begin
                    r_state     <= ST_PLAY;
                    r_clear_n   <= 1'b1;
                    r_initpos_n <= 1'b1;
                    r_rep_cnt   <= '0;
                    r_hit_cnt   <= '0;
                end

                ST_PLAY: begin
                    r_clear_n   <= 1'b1;
                    r_initpos_n <= 1'b1;
                    if (SC_REGJUGCTRL_collision_In) begin
                        // Collision wins over any move scheduled this cycle.
                        r_state   <= ST_HIT;
                        r_lives   <= lives_dec(r_lives);
                        r_rep_cnt <= '0;
                        r_hit_cnt <= '0;
                    end else if (!w_left_level && !w_right_level) begin
                        // Conflicting buttons: hold and restart the period.
                        r_rep_cnt <= '0;
                    end else if (w_left_fall) begin
                        r_shift   <= SHIFT_LEFT;
                        r_rep_cnt <= '0;
                    end else if (w_right_fall) begin
                        r_shift   <= SHIFT_RIGHT;
                        r_rep_cnt <= '0;
                    end else if (!w_left_level || !w_right_level) begin
                        // One button held: auto-repeat once per full period.
                        if (r_rep_cnt >= REP_LAST) begin
                            r_rep_cnt <= '0;
                            r_shift   <= w_left_level ? SHIFT_RIGHT : SHIFT_LEFT;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + TICK_WIDTH'(1);
                        end
                    end else begin
                        r_rep_cnt <= '0;
                    end
                end

                ST_HIT: begin
                    // Register holds for display; collision is not looked at.
                    r_clear_n   <= 1'b1;
                    r_initpos_n <= 1'b1;
                    r_rep_cnt   <= '0;
                    if (r_hit_cnt >= HIT_LAST) begin
                        r_hit_cnt <= '0;
                        if (r_lives != LIVES_W'(0)) begin
                            r_state     <= ST_SPAWN;
                            r_initpos_n <= 1'b0;
                        end else begin
                            r_state <= ST_OVER;
                        end
                    end else begin
                        r_hit_cnt <= r_hit_cnt + HIT_WIDTH'(1);
                    end
                end

                ST_OVER: begin
                    r_clear_n   <= 1'b1;
                    r_initpos_n <= 1'b1;
                    r_lives     <= '0;
                    r_rep_cnt   <= '0;
                    r_hit_cnt   <= '0;
                    if (w_start_evt) begin
                        r_state     <= ST_SPAWN;
                        r_lives     <= LIVES_FULL;
                        r_initpos_n <= 1'b0;
                    end
                end

                default: begin
                    // Illegal code: fall back to the reset picture.
                    r_state     <= ST_IDLE;
                    r_lives     <= LIVES_FULL;
                    r_clear_n   <= 1'b0;
                    r_initpos_n <= 1'b1;
                    r_rep_cnt   <= '0;
                    r_hit_cnt   <= '0;
                end
            endcase
        end
    end

    assign SC_REGJUGCTRL_shiftselection_Out = r_shift;
    assign SC_REGJUGCTRL_clear_OutLow       = r_clear_n;
    assign SC_REGJUGCTRL_initpos_OutLow     = r_initpos_n;
    assign SC_REGJUGCTRL_lives_Out          = r_lives;
    assign SC_REGJUGCTRL_state_Out          = r_state;

endmodule
